cpu_program_loader: RTL and testbench

//   Upstream feeder for the CPU's memory-load port. Accepts a byte stream over a

---
 rtl/cpu_program_loader.sv | 147 ++++++++++++++
 tb/tb_cpu_program_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_loader.sv
// Byte-stream program loader: parses framed load/run commands and writes
// big-endian 32-bit words into the CPU's instruction or data memory.
module cpu_program_loader #(
  parameter int          ADDR_W   = 10,
  parameter logic [7:0]  HDR_INST = 8'hA5,
  parameter logic [7:0]  HDR_DATA = 8'h5A,
  parameter logic [7:0]  HDR_RUN  = 8'hC3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] address,
  output logic              write_instruction,
  output logic              write_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              error
);

  // The high address byte only contributes the bits above the low byte,
  // so this loader supports 9 <= ADDR_W <= 16.
  localparam int HI_W = ADDR_W - 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE
  } state_t;

  state_t          state;
  logic            target_inst;
  logic [HI_W-1:0] addr_hi;
  logic [7:0]      cnt_hi;
  logic [15:0]     count;
  logic [23:0]     word;
  logic [1:0]      byte_idx;
  logic            accept;
  logic [15:0]     cnt_full;

  assign accept   = in_valid & in_ready;
  assign cnt_full = {cnt_hi, in_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      target_inst       <= 1'b0;
      addr_hi           <= '0;
      cnt_hi            <= 8'd0;
      count             <= 16'd0;
      word              <= 24'd0;
      byte_idx          <= 2'd0;
      in_ready          <= 1'b0;
      inst_data         <= 32'd0;
      address           <= '0;
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      cpu_rst           <= 1'b1;
      busy              <= 1'b0;
      error             <= 1'b0;
    end else begin
      // Strobes are single-cycle; in_ready only drops for the WRITE cycle.
      in_ready          <= 1'b1;
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_data == HDR_INST || in_data == HDR_DATA) begin
              target_inst <= (in_data == HDR_INST);
              cpu_rst     <= 1'b1;
              busy        <= 1'b1;
              state       <= ADDR_HI;
            end else if (in_data == HDR_RUN) begin
              cpu_rst <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ADDR_HI: begin
          if (accept) begin
            addr_hi <= in_data[HI_W-1:0];
            state   <= ADDR_LO;
          end
        end
        ADDR_LO: begin
          if (accept) begin
            address <= {addr_hi, in_data};
            state   <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (accept) begin
            cnt_hi <= in_data;
            state  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            if (cnt_full == 16'd0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              count    <= cnt_full;
              byte_idx <= 2'd0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (byte_idx == 2'd3) begin
              inst_data         <= {word, in_data};
              write_instruction <= target_inst;
              write_data        <= ~target_inst;
              in_ready          <= 1'b0;
              byte_idx          <= 2'd0;
              state             <= WRITE;
            end else begin
              word     <= {word[15:0], in_data};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          address <= address + 1'b1;
          count   <= count - 16'd1;
          if (count == 16'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed, table-driven bench for cpu_program_loader: frames are streamed
// byte by byte and every memory write strobe is captured and compared.
module tb_cpu_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic [31:0] instData;
  logic [9:0]  address;
  logic        writeInstruction;
  logic        writeData;
  logic        cpuRst;
  logic        busy;
  logic        error;

  cpu_program_loader #(.ADDR_W(10)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_data           (inData),
    .in_valid          (inValid),
    .in_ready          (inReady),
    .inst_data         (instData),
    .address           (address),
    .write_instruction (writeInstruction),
    .write_data        (writeData),
    .cpu_rst           (cpuRst),
    .busy              (busy),
    .error             (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [103:0] frame;
    int           len;
    int           gap;
    int           nWr;
    logic         isInst;
    logic [9:0]   a0;
    logic [9:0]   a1;
    logic [31:0]  d0;
    logic [31:0]  d1;
    logic         expErr;
    logic         expCpuRst;
  } vec_t;

  typedef struct {
    logic        isInst;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        cpuRst;
  } wr_t;

  vec_t vecs[7];
  wr_t  wrQ[$];
  wr_t  wrCap;
  int   checks = 0;
  int   errors = 0;
  int   stallBad = 0;
  int   bothHigh = 0;
  bit   stallMon = 1'b0;

  // Capture every write strobe, and during stalled runs confirm that
  // in_ready is low exactly when a strobe is high.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (writeInstruction && writeData) bothHigh++;
      if (writeInstruction || writeData) begin
        wrCap.isInst = writeInstruction;
        wrCap.addr   = address;
        wrCap.data   = instData;
        wrCap.cpuRst = cpuRst;
        wrQ.push_back(wrCap);
      end
      if (stallMon && (inReady !== !(writeInstruction || writeData))) stallBad++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) begin
      inValid = 1'b0;
      @(negedge clk);
    end
    inData  = b;
    inValid = 1'b1;
    tries   = 0;
    while (!inReady && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!inReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout actual=in_ready 0 expected=in_ready 1 byte=%h", b);
    end
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic runVector(input int i);
    vec_t v;
    logic [7:0] b;
    v = vecs[i];
    wrQ.delete();
    stallBad = 0;
    stallMon = (v.gap != 0);
    for (int j = 0; j < v.len; j++) begin
      b = v.frame[103-8*j -: 8];
      applyStimulus(b, v.gap);
    end
    repeat (3) @(negedge clk);
    stallMon = 1'b0;
    checkOutput({v.name, " write count"}, wrQ.size(), v.nWr);
    for (int k = 0; k < v.nWr && k < wrQ.size(); k++) begin
      checkOutput({v.name, " strobe kind"}, wrQ[k].isInst, v.isInst);
      checkOutput({v.name, " address"}, wrQ[k].addr, (k == 0) ? v.a0 : v.a1);
      checkOutput({v.name, " word"}, wrQ[k].data, (k == 0) ? v.d0 : v.d1);
      checkOutput({v.name, " cpu_rst at strobe"}, wrQ[k].cpuRst, 1'b1);
    end
    checkOutput({v.name, " busy after"}, busy, 1'b0);
    checkOutput({v.name, " error"}, error, v.expErr);
    checkOutput({v.name, " cpu_rst"}, cpuRst, v.expCpuRst);
    checkOutput({v.name, " in_ready idle"}, inReady, 1'b1);
    if (v.gap != 0) checkOutput({v.name, " in_ready vs WRITE"}, stallBad, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"inst load", 104'hA500000002_07E0000A_07C0000A, 13, 0, 2, 1'b1,
                10'd0, 10'd1, 32'h07E0000A, 32'h07C0000A, 1'b0, 1'b1};
    vecs[1] = '{"data wrap", 104'h5A03FF0002_11111111_22222222, 13, 0, 2, 1'b0,
                10'd1023, 10'd0, 32'h11111111, 32'h22222222, 1'b0, 1'b1};
    vecs[2] = '{"stalled inst", 104'hA500000002_07E0000A_07C0000A, 13, 3, 2, 1'b1,
                10'd0, 10'd1, 32'h07E0000A, 32'h07C0000A, 1'b0, 1'b1};
    vecs[3] = '{"count zero", {40'hA500100000, 64'h0}, 5, 0, 0, 1'b1,
                10'd0, 10'd0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{"load after run", {72'hA500050001_DEADBEEF, 32'h0}, 9, 0, 1, 1'b1,
                10'd5, 10'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1};
    vecs[5] = '{"bad header", {8'h77, 96'h0}, 1, 0, 0, 1'b1,
                10'd0, 10'd0, 32'h0, 32'h0, 1'b1, 1'b1};
    vecs[6] = '{"data after error", {72'h5A00070001_CAFE0001, 32'h0}, 9, 0, 1, 1'b0,
                10'd7, 10'd0, 32'hCAFE0001, 32'h0, 1'b1, 1'b1};

    rst     = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    @(negedge clk);
    checkOutput("reset cpu_rst", cpuRst, 1'b1);
    checkOutput("reset write_instruction", writeInstruction, 1'b0);
    checkOutput("reset write_data", writeData, 1'b0);
    checkOutput("reset address", address, 10'd0);
    checkOutput("reset error", error, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset in_ready", inReady, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", inReady, 1'b1);

    for (int i = 0; i < 4; i++) runVector(i);

    // RUN releases the CPU on the accepting edge; a repeat RUN changes nothing.
    checkOutput("cpu_rst before run", cpuRst, 1'b1);
    applyStimulus(8'hC3, 0);
    checkOutput("cpu_rst after run", cpuRst, 1'b0);
    checkOutput("busy after run", busy, 1'b0);
    applyStimulus(8'hC3, 0);
    checkOutput("cpu_rst after repeat run", cpuRst, 1'b0);
    applyStimulus(8'hA5, 0);
    checkOutput("cpu_rst on load header", cpuRst, 1'b1);
    checkOutput("busy on load header", busy, 1'b1);
    for (int j = 1; j < 9; j++) applyStimulus(vecs[4].frame[103-8*j -: 8], 0);
    repeat (3) @(negedge clk);
    wrQ.delete();

    for (int i = 4; i < 7; i++) runVector(i);
    checkOutput("never both strobes", bothHigh, 0);

    // Reset after two data bytes of a word: everything returns to reset values.
    wrQ.delete();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    checkOutput("busy mid-word", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async busy", busy, 1'b0);
    checkOutput("async cpu_rst", cpuRst, 1'b1);
    checkOutput("async address", address, 10'd0);
    checkOutput("async error", error, 1'b0);
    checkOutput("async in_ready", inReady, 1'b0);
    checkOutput("async strobes", {writeInstruction, writeData}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("no strobe after abort", wrQ.size(), 0);
    checkOutput("idle after abort", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
